// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the multistage MIPS datapath.
//   - Latches the two register-file read values, the decoded fields and the
//     EX/MEM/WB control bundle into the EX slot.
//   - Bypasses the WB write into the operands. The register file writes on
//     the same clock edge, so a same-cycle read would otherwise be stale.
//   - Detects load-use hazards and turns the EX slot into a bubble. Branch
//     flushes also produce a bubble.
//   - Keeps a saturating count of stalled cycles for debug.
//
// Ports
//   clock, reset       pipeline clock; asynchronous active-high reset
//   id_*               decoded instruction currently in ID
//   rf_rs/rt_data      register file read data for id_rs / id_rt
//   wb_reg_write/rd/data  WB write port (same signals that drive the regfile)
//   flush              taken branch/jump resolved in EX; kill the ID slot
//   stall              combinational; upstream holds PC and IF/ID while high
//   ex_*               EX slot contents
//   stall_cnt          saturating count of edges on which stall was high
//
// Handshake: stall is the only backpressure. While stall=1 the upstream
// stages must present the same ID instruction on the next cycle. This stage
// inserts a bubble itself, and the stall lasts exactly one cycle. The next
// cycle the bubble clears ex_valid, so the held instruction advances.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [31:0]       rf_rs_data,
  input  logic [31:0]       rf_rt_data,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hz;

  // Operand select. $0 always reads zero, even if WB targets it.
  always_comb begin
    rs_val = rf_rs_data;
    if (id_rs == 5'd0)
      rs_val = 32'd0;
    else if (wb_reg_write && (wb_rd == id_rs))
      rs_val = wb_data;
  end

  always_comb begin
    rt_val = rf_rt_data;
    if (id_rt == 5'd0)
      rt_val = 32'd0;
    else if (wb_reg_write && (wb_rd == id_rt))
      rt_val = wb_data;
  end

  // A load in EX cannot forward its data in time for a dependent
  // instruction in ID. rt matters only if the instruction reads it.
  assign hz = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
              ((id_rs == ex_rd) || (id_uses_rt && (id_rt == ex_rd)));

  // A flush kills the ID instruction anyway, so holding it would be useless.
  assign stall = hz && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_rs_data   <= 32'd0;
      ex_rt_data   <= 32'd0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_rd        <= 5'd0;
      ex_imm       <= 32'd0;
      ex_pc        <= 32'd0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush || hz) begin
      // Bubble: every field is zeroed, not only the control bits.
      ex_valid     <= 1'b0;
      ex_rs_data   <= 32'd0;
      ex_rt_data   <= 32'd0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_rd        <= 5'd0;
      ex_imm       <= 32'd0;
      ex_pc        <= 32'd0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_rs_data   <= rs_val;
      ex_rt_data   <= rt_val;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_imm       <= id_imm;
      ex_pc        <= id_pc;
      // An empty slot must never carry side-effecting control downstream.
      ex_ctrl      <= id_valid ? id_ctrl : '0;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_reg_write <= id_valid && id_reg_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
  localparam int VW     = 1 + 32 + 32 + 5 + 5 + 5 + 32 + 32 + CTRL_W + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic              id_valid, id_uses_rt, id_mem_read, id_reg_write;
  logic [4:0]        id_rs, id_rt, id_rd, wb_rd;
  logic [31:0]       id_imm, id_pc, rf_rs_data, rf_rt_data, wb_data;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write, flush;

  logic              stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0]       ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  // second instance with a 2-bit counter for saturation
  logic              s_stall, s_ex_valid, s_ex_mem_read, s_ex_reg_write;
  logic [31:0]       s_ex_rs_data, s_ex_rt_data, s_ex_imm, s_ex_pc;
  logic [4:0]        s_ex_rs, s_ex_rt, s_ex_rd;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic [1:0]        s_stall_cnt;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .stall(s_stall),
    .ex_valid(s_ex_valid), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_imm(s_ex_imm), .ex_pc(s_ex_pc),
    .ex_ctrl(s_ex_ctrl), .ex_mem_read(s_ex_mem_read), .ex_reg_write(s_ex_reg_write),
    .stall_cnt(s_stall_cnt)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {ex_valid, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_rd,
                    ex_imm, ex_pc, ex_ctrl, ex_mem_read, ex_reg_write};

  // ---------------- scoreboard / model ----------------
  logic [VW-1:0]    exp_q[$];
  logic [VW-1:0]    exp_v;
  int               n_cmp  = 0;
  int               n_fail = 0;
  logic             m_valid, m_mem_read;
  logic [4:0]       m_rd;
  logic [CNT_W-1:0] m_cnt;
  logic [1:0]       m_cnt2;

  function automatic logic [31:0] opnd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_rd = 0;
    id_imm = 0; id_pc = 0; id_ctrl = 0; id_mem_read = 0; id_reg_write = 0;
    rf_rs_data = 0; rf_rt_data = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    flush = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                             input logic [4:0] rd, input logic mr, input logic rw);
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_rd = rd;
    id_mem_read = mr; id_reg_write = rw;
    id_imm = $urandom; id_pc = $urandom; id_ctrl = CTRL_W'($urandom);
    rf_rs_data = $urandom; rf_rt_data = $urandom;
  endtask

  // Inputs are already driven (just after a rising edge). Computes expected
  // stall and next EX contents from the model, pushes the expectation,
  // samples stall, then advances one clock.
  task automatic step(output logic obs_stall, output logic exp_stall);
    logic hz;
    #1;
    hz = id_valid && m_valid && m_mem_read && (m_rd != 0) &&
         ((id_rs == m_rd) || (id_uses_rt && id_rt == m_rd));
    exp_stall = hz && !flush;
    obs_stall = stall;
    if (flush || hz)
      exp_q.push_back('0);
    else
      exp_q.push_back({id_valid, opnd(id_rs, rf_rs_data), opnd(id_rt, rf_rt_data),
                       id_rs, id_rt, id_rd, id_imm, id_pc,
                       id_valid ? id_ctrl : {CTRL_W{1'b0}},
                       id_valid && id_mem_read, id_valid && id_reg_write});
    if (flush || hz) begin
      m_valid = 0; m_mem_read = 0; m_rd = 0;
    end else begin
      m_valid = id_valid; m_mem_read = id_valid && id_mem_read; m_rd = id_rd;
    end
    if (exp_stall && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (exp_stall && m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #2 reset = 0;
    m_valid = 0; m_mem_read = 0; m_rd = 0; m_cnt = 0; m_cnt2 = 0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic os, es;
    n_cmp++;
    if (dut_vec !== '0 || stall_cnt !== '0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: ex=%h cnt=%0d stall=%b, want all 0", dut_vec, stall_cnt, stall);
    end
    // Set up a live hazard, then reset mid-cycle.
    drive_instr(5'd1, 5'd2, 1, 5'd8, 1, 1);
    step(os, es);
    exp_v = exp_q.pop_front();
    drive_instr(5'd8, 5'd3, 1, 5'd9, 0, 1);
    #2 reset = 1;
    #1;
    n_cmp++;
    if (dut_vec !== '0 || stall_cnt !== '0 || stall !== 1'b0 || s_stall_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: ex=%h cnt=%0d stall=%b, want all 0", dut_vec, stall_cnt, stall);
    end
    #1 reset = 0;
    m_valid = 0; m_mem_read = 0; m_rd = 0; m_cnt = 0; m_cnt2 = 0;
    exp_q.delete();
    @(posedge clock); #1;
    drive_idle();
    step(os, es);
    exp_v = exp_q.pop_front();
  endtask

  task automatic test_bypass();
    logic os, es;
    drive_instr(5'd5, 5'd6, 1, 5'd7, 0, 1);
    rf_rs_data = 32'h1;
    wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ex_rs_data !== 32'hDEADBEEF || dut_vec !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_rs: got rs_data=%h ex=%h, want %h ex=%h", ex_rs_data, dut_vec, 32'hDEADBEEF, exp_v);
    end
    // rt bypass
    drive_instr(5'd3, 5'd12, 1, 5'd7, 0, 1);
    wb_reg_write = 1; wb_rd = 5'd12; wb_data = 32'h0BADF00D;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ex_rt_data !== 32'h0BADF00D || dut_vec !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_rt: got rt_data=%h, want %h", ex_rt_data, 32'h0BADF00D);
    end
    // $0 never bypassed, reads 0
    drive_instr(5'd0, 5'd0, 1, 5'd7, 0, 1);
    rf_rs_data = 32'h1;
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0 || dut_vec !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_zero: got rs=%h rt=%h, want 0", ex_rs_data, ex_rt_data);
    end
    // write enable low: no bypass
    drive_instr(5'd5, 5'd6, 1, 5'd7, 0, 1);
    wb_reg_write = 0; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ex_rs_data !== rf_rs_data || dut_vec !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_wen_low: got rs=%h, want %h", ex_rs_data, rf_rs_data);
    end
    drive_idle();
  endtask

  task automatic test_load_use();
    logic os, es;
    logic [CNT_W-1:0] c0;
    c0 = m_cnt;
    drive_instr(5'd1, 5'd2, 0, 5'd8, 1, 1);    // lw $8
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dut_vec !== exp_v || ex_mem_read !== 1'b1 || ex_rd !== 5'd8) begin
      n_fail++;
      $display("FAIL lu_load: ex=%h, want %h", dut_vec, exp_v);
    end
    drive_instr(5'd8, 5'd3, 1, 5'd9, 0, 1);    // add $9,$8,$3
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (os !== 1'b1 || es !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: got stall=%b, want 1", os);
    end
    n_cmp++;
    if (dut_vec !== exp_v || ex_valid !== 1'b0 || stall_cnt !== c0 + 1'b1) begin
      n_fail++;
      $display("FAIL lu_bubble: ex_valid=%b cnt=%0d, want 0 cnt=%0d", ex_valid, stall_cnt, c0 + 1'b1);
    end
    step(os, es);                                // held add advances
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (os !== 1'b0 || dut_vec !== exp_v || ex_valid !== 1'b1 || stall_cnt !== c0 + 1'b1) begin
      n_fail++;
      $display("FAIL lu_advance: stall=%b ex=%h cnt=%0d, want 0 ex=%h cnt=%0d", os, dut_vec, stall_cnt, exp_v, c0 + 1'b1);
    end
    drive_idle();
  endtask

  task automatic test_rt_gating();
    logic os, es;
    drive_instr(5'd1, 5'd2, 0, 5'd8, 1, 1);    // lw $8
    step(os, es);
    exp_v = exp_q.pop_front();
    drive_instr(5'd4, 5'd8, 0, 5'd8, 0, 1);    // addi: rt is dest, not read
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (os !== 1'b0 || dut_vec !== exp_v || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rt_unused: stall=%b ex=%h, want 0 ex=%h", os, dut_vec, exp_v);
    end
    drive_instr(5'd1, 5'd2, 0, 5'd8, 1, 1);    // lw $8 again
    step(os, es);
    exp_v = exp_q.pop_front();
    drive_instr(5'd4, 5'd8, 1, 5'd10, 0, 1);   // R-type reading rt=$8
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (os !== 1'b1 || dut_vec !== exp_v) begin
      n_fail++;
      $display("FAIL rt_used: stall=%b ex=%h, want 1 ex=%h", os, dut_vec, exp_v);
    end
    step(os, es);
    exp_v = exp_q.pop_front();
    drive_idle();
  endtask

  task automatic test_flush();
    logic os, es;
    logic [CNT_W-1:0] c0;
    drive_instr(5'd1, 5'd2, 0, 5'd8, 1, 1);
    step(os, es);
    exp_v = exp_q.pop_front();
    c0 = m_cnt;
    drive_instr(5'd8, 5'd3, 1, 5'd9, 0, 1);
    flush = 1;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (os !== 1'b0 || dut_vec !== exp_v || dut_vec !== '0 || stall_cnt !== c0) begin
      n_fail++;
      $display("FAIL flush_beats_stall: stall=%b ex=%h cnt=%0d, want 0 ex=0 cnt=%0d", os, dut_vec, stall_cnt, c0);
    end
    // flush of an ordinary instruction
    drive_instr(5'd4, 5'd5, 1, 5'd6, 0, 1);
    flush = 1;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL flush_plain: ex=%h, want 0", dut_vec);
    end
    drive_idle();
  endtask

  task automatic test_invalid_slot();
    logic os, es;
    drive_instr(5'd4, 5'd5, 1, 5'd6, 1, 1);
    id_valid = 0; id_ctrl = 8'hFF;
    step(os, es);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (dut_vec !== exp_v || ex_ctrl !== '0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_gating: ex=%h, want %h", dut_vec, exp_v);
    end
    drive_idle();
  endtask

  task automatic test_saturation();
    logic os, es;
    logic [1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    do_reset();
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      drive_instr(5'd1, 5'd2, 0, 5'd8, 1, 1);
      step(os, es);
      exp_v = exp_q.pop_front();
      drive_instr(5'd8, 5'd3, 1, 5'd9, 0, 1);
      step(os, es);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (s_stall_cnt !== want[i] || s_stall_cnt !== m_cnt2 || s_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %0d, want %0d", i, s_stall_cnt, want[i]);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL wide_cnt: got %0d, want 5", stall_cnt);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic os, es;
    for (int i = 0; i < 60; i++) begin
      drive_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      id_valid     = ($urandom_range(0, 7) != 0);
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 3));
      wb_data      = $urandom;
      flush        = ($urandom_range(0, 7) == 0);
      step(os, es);
      n_cmp++;
      if (os !== es) begin
        n_fail++;
        $display("FAIL b2b_stall[%0d]: got %b, want %b", i, os, es);
      end
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b2b_queue[%0d]: empty scoreboard, want 1 entry", i);
      end else begin
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (dut_vec !== exp_v || stall_cnt !== m_cnt) begin
          n_fail++;
          $display("FAIL b2b_ex[%0d]: ex=%h cnt=%0d, want ex=%h cnt=%0d", i, dut_vec, stall_cnt, exp_v, m_cnt);
        end
      end
    end
    drive_idle();
  endtask

  // ---------------- main ----------------
  initial begin
    drive_idle();
    m_valid = 0; m_mem_read = 0; m_rd = 0; m_cnt = 0; m_cnt2 = 0;
    #1;
    test_reset_hold();
    test_reset();
    test_bypass();
    test_load_use();
    test_rt_gating();
    test_flush();
    test_invalid_slot();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Reset held across an edge: outputs stay cleared; then release between edges.
  task automatic test_reset_hold();
    @(posedge clock); #1;
    n_cmp++;
    if (dut_vec !== '0 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: ex=%h cnt=%0d, want 0", dut_vec, stall_cnt);
    end
    #2 reset = 0;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (register-file read) and execute in the multistage MIPS datapath.
- Latches the two register-file read values, the decoded fields and the control bits into EX.
- Applies WB→ID bypass: the register file writes on the clock edge, so same-cycle reads would otherwise return stale data.
- Detects load-use hazards, inserts bubbles, and honours branch flushes; keeps a saturating stall counter for debug.

Parameters:
- CTRL_W, 8, width of opaque EX/MEM/WB control bundle passed through
- CNT_W, 16, width of stall counter

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  decode slot holds a real instruction
- id_rs  in  5  source register 1 index
- id_rt  in  5  source register 2 index
- id_uses_rt  in  1  instruction reads rt (R-type, store, beq/bne)
- id_rd  in  5  destination register index (already muxed rd/rt)
- id_imm  in  32  sign/zero-extended immediate
- id_pc  in  32  PC+4 of instruction
- id_ctrl  in  CTRL_W  control bundle
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes the register file
- rf_rs_data  in  32  register file output for rs
- rf_rt_data  in  32  register file output for rt
- wb_reg_write  in  1  WB stage write enable (same signal driving the regfile)
- wb_rd  in  5  WB destination
- wb_data  in  32  WB write data
- flush  in  1  branch/jump resolved taken in EX; kill decode slot
- stall  out  1  combinational; upstream must hold PC and IF/ID while high
- ex_valid  out  1  EX slot holds a real instruction
- ex_rs_data, ex_rt_data  out  32 each  operand values
- ex_rs, ex_rt, ex_rd  out  5 each  register indices for EX forwarding
- ex_imm, ex_pc  out  32 each
- ex_ctrl  out  CTRL_W
- ex_mem_read, ex_reg_write  out  1 each
- stall_cnt  out  CNT_W  cycles spent stalled, saturating

Behaviour:
- Reset (async, any time): every ex_* output and stall_cnt go to 0. stall reads 0 while reset is high. No partial update on the edge reset is released.
- Operand select, per operand:
  - index 0 → 0;
  - else wb_reg_write && wb_rd==index → wb_data;
  - else rf_*_data.
- Load-use hazard: hz = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && (id_rs==ex_rd || (id_uses_rt && id_rt==ex_rd)).
- stall = hz && !flush.
- Priority on each rising edge:
  1. flush → bubble: ex_valid, ex_ctrl, ex_mem_read, ex_reg_write = 0; other fields don't-care but driven 0.
  2. hz → bubble, same as above.
  3. Otherwise latch all id_* fields and operands. ex_valid = id_valid. When id_valid=0, ex_ctrl, ex_mem_read and ex_reg_write are forced 0.
- A stall lasts exactly one cycle: the bubble clears ex_valid, so hz is 0 on the next cycle and the held instruction advances. A reload after a bubble is the load's new EX occupant, not the original load.
- Latency: an instruction present in ID at edge N appears on ex_* after edge N (one cycle). Bypass adds no latency.
- stall_cnt increments by 1 on each edge where stall=1 and saturates at all-ones. It is not cleared by flush.
- No combinational path from ex_* outputs to id_* inputs other than through stall.

Test Plan:
- Reset mid-run: drive a valid instruction, assert reset between edges → all ex_* = 0 immediately, stall_cnt = 0, stall = 0.
- Bypass: wb_reg_write=1, wb_rd=5, wb_data=32'hDEADBEEF, rf_rs_data=32'h1, id_rs=5 → next edge ex_rs_data = 32'hDEADBEEF. Repeat with id_rs=0 and wb_rd=0 → ex_rs_data = 0.
- Load-use: lw $8 into EX (ex_mem_read=1, ex_rd=8), then add with id_rs=8 → stall=1 for exactly one cycle; a bubble (ex_valid=0) enters EX; next edge the add latches; stall_cnt = 1.
- rt hazard gating: same lw, id_rt=8, id_uses_rt=0 (addi) → stall=0 and the instruction latches. With id_uses_rt=1 → stall=1.
- Flush beats stall: load-use condition true and flush=1 on the same cycle → stall=0, bubble inserted, stall_cnt unchanged.
- Counter saturation: CNT_W=2, force 5 consecutive load-use stalls → stall_cnt sequence 1, 2, 3, 3, 3.
